shift_normalizer: RTL and testbench
===================================

Name: shift_normalizer

Overview:
- Iterative left-normalizer for the execute-stage shift datapath. It recovers the shift amount that normalizes a word, which is the inverse of applying a shamt to a word.
- Unsigned mode shifts left until bit MSB is 1 (leading-zero count).
- Signed mode shifts left until bit MSB differs from bit MSB-1 (redundant-sign-bit count).
- Multi-cycle, one bit per clock, with a start/busy/done handshake toward the controller FSM.

Parameters:
- WIDTH, 32, data word width; must be at least 2.
- CW, 6, count width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = unsigned (count leading zeros), 1 = signed (count redundant sign bits); captured with start.
- data_in  input  WIDTH  operand; captured with start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  normalized word.
- shamt  output  CW  number of left shifts applied.
- zero  output  1  captured operand was all zeros.

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, zero = 0.
  - result = 0, shamt = 0.
  - Internal working register and counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures data_in into the working register and mode into a mode register; clears the counter.
  - Special cases detected at capture go straight to DONE, skipping SHIFT:
    - unsigned and data_in==0: shamt=WIDTH, result=0, zero=1.
    - signed and data_in==0: shamt=WIDTH-1, result=0, zero=1.
    - signed and data_in all ones: shamt=WIDTH-1, result=all ones, zero=0.
  - Otherwise go to SHIFT with zero=0.
  - start=0: stay in IDLE; outputs hold their last values.
- SHIFT, one evaluation per cycle:
  - Normalized test: unsigned means reg[WIDTH-1]==1; signed means reg[WIDTH-1]!=reg[WIDTH-2].
  - If normalized: result<=reg, shamt<=counter, then go to DONE.
  - Else: reg<=reg<<1 (zero fill), counter<=counter+1, stay in SHIFT.
  - The counter cannot exceed WIDTH-1 for a nonzero operand, so no overflow guard beyond the special cases is needed.
- DONE: done=1 for exactly one cycle, then return to IDLE; busy falls with done.
- Latency, counted from the clock edge that samples start:
  - Normal operand: done is high k+2 cycles later, where k = shamt. Total occupancy is k+2 cycles.
  - Special case: done is high 1 cycle later.
- start during SHIFT or DONE is ignored; there is no queueing. A new start is accepted the cycle after done, in IDLE.
- result, shamt and zero stay stable from done until the next accepted start completes.
  - They may be overwritten only on SHIFT-exit or special-case capture.
  - They are never cleared at start.
- mode and data_in changes after capture have no effect on an operation in flight.
- Reset mid-operation aborts immediately to IDLE with all outputs at reset values; no done pulse is generated.
- Result invariant: for a nonzero operand, result == data_in << shamt (truncated to WIDTH).

Decomposition:
- Shared header `shift_defs`:
  - FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Mode constants MODE_UNS=1'b0 and MODE_SGN=1'b1.
  - These are reused by the shifter control decode.
- One natural sub-module, `norm_detect`, is combinational.
  - Inputs: working register and mode.
  - Outputs: normalized flag, plus the all-zero and all-one flags used at capture.
- FSM, counter and output registers live in the top module.

Test Plan:
- Unsigned 0x0000_0001 -> shamt=31, result=0x8000_0000, zero=0; done 33 cycles after start; busy high throughout.
- Unsigned 0x8000_0000 -> shamt=0, result=0x8000_0000; done 2 cycles after start.
- Signed 0xFFFF_F000 -> shamt=19, result=0x8000_0000. Signed 0x0000_0001 -> shamt=30, result=0x4000_0000.
- Special cases:
  - Unsigned 0 -> shamt=32, zero=1.
  - Signed 0 -> shamt=31, zero=1.
  - Signed 0xFFFF_FFFF -> shamt=31, result=0xFFFF_FFFF, zero=0.
  - Each has done 1 cycle after start.
- Start pulsed with 0x0000_00FF while a 0x0000_0001 operation is busy -> ignored; first op completes with shamt=31; second start accepted after done gives shamt=24.
- rst_n low 10 cycles into 0x0000_0001 -> all outputs 0 immediately, no done pulse; a subsequent start with 0x0001_0000 unsigned -> shamt=15.

Source files
------------

// File: rtl/shift_normalizer_pkg.sv
// Shared definitions for the shift normalizer: FSM state encodings and mode constants.
package shift_normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_UNS = 1'b0;
  localparam logic MODE_SGN = 1'b1;

endpackage

// File: rtl/shift_normalizer_norm_detect.sv
// Combinational normalization test plus all-zero / all-one detection of a word.
module shift_normalizer_norm_detect
  import shift_normalizer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic             mode,
  output logic             normalized,
  output logic             all_zero,
  output logic             all_one
);

  // Signed words are normalized once the top two bits disagree.
  assign normalized = (mode == MODE_UNS) ? word[WIDTH-1]
                                         : (word[WIDTH-1] ^ word[WIDTH-2]);
  assign all_zero   = ~|word;
  assign all_one    = &word;

endmodule

// File: rtl/shift_normalizer.sv
// Iterative left-normalizer: shifts one bit per clock until the word is normalized
// and reports the shift count (leading zeros or redundant sign bits).
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    shamt,
  output logic             zero
);

  localparam logic [CW-1:0] SHAMT_UNS_ZERO = CW'(WIDTH);
  localparam logic [CW-1:0] SHAMT_SGN_FULL = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic             mode_reg, mode_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CW-1:0]    shamt_reg, shamt_next;
  logic             zero_reg, zero_next;

  logic [WIDTH-1:0] det_word;
  logic             det_mode;
  logic             normalized, all_zero, all_one;

  // In IDLE the detector looks at the incoming operand so special cases are caught at capture.
  assign det_word = (state_reg == IDLE) ? data_in : work_reg;
  assign det_mode = (state_reg == IDLE) ? mode : mode_reg;

  shift_normalizer_norm_detect #(.WIDTH(WIDTH)) u_detect (
    .word       (det_word),
    .mode       (det_mode),
    .normalized (normalized),
    .all_zero   (all_zero),
    .all_one    (all_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      work_reg   <= '0;
      mode_reg   <= MODE_UNS;
      cnt_reg    <= '0;
      result_reg <= '0;
      shamt_reg  <= '0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      mode_reg   <= mode_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      shamt_reg  <= shamt_next;
      zero_reg   <= zero_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    mode_next   = mode_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    shamt_next  = shamt_reg;
    zero_next   = zero_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          work_next = data_in;
          mode_next = mode;
          cnt_next  = '0;
          if (mode == MODE_UNS && all_zero) begin
            result_next = '0;
            shamt_next  = SHAMT_UNS_ZERO;
            zero_next   = 1'b1;
            state_next  = DONE;
          end else if (mode == MODE_SGN && (all_zero || all_one)) begin
            result_next = all_one ? '1 : '0;
            shamt_next  = SHAMT_SGN_FULL;
            zero_next   = all_zero;
            state_next  = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        // Outputs are only touched on exit so they stay stable while shifting.
        if (normalized) begin
          result_next = work_reg;
          shamt_next  = cnt_reg;
          zero_next   = 1'b0;
          state_next  = DONE;
        end else begin
          work_next = {work_reg[WIDTH-2:0], 1'b0};
          cnt_next  = cnt_reg + CW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state_reg == SHIFT) || (state_reg == DONE);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign shamt  = shamt_reg;
  assign zero   = zero_reg;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed, table-driven bench for shift_normalizer with hand-computed expectations.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] data_in = '0;
  logic        busy, done, zero;
  logic [31:0] result;
  logic [5:0]  shamt;

  int checks = 0;
  int errors = 0;

  shift_normalizer #(.WIDTH(32), .CW(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .shamt   (shamt),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [31:0] data;
    logic [5:0]  shamt;
    logic [31:0] result;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive start across one rising edge; returns just after the sampling edge.
  task automatic launch(input logic m, input logic [31:0] d);
    @(negedge clk);
    start   = 1'b1;
    mode    = m;
    data_in = d;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mode    = ~m;
    data_in = ~d;
  endtask

  // Latency in cycles after the first negedge searched; -1 on timeout.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = c + 1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    bit bok;

    vecs[0]  = '{1'b0, 32'h0000_0001, 6'd31, 32'h8000_0000, 1'b0, 33};
    vecs[1]  = '{1'b0, 32'h8000_0000, 6'd0,  32'h8000_0000, 1'b0, 2};
    vecs[2]  = '{1'b1, 32'hFFFF_F000, 6'd19, 32'h8000_0000, 1'b0, 21};
    vecs[3]  = '{1'b1, 32'h0000_0001, 6'd30, 32'h4000_0000, 1'b0, 32};
    vecs[4]  = '{1'b0, 32'h0000_0000, 6'd32, 32'h0000_0000, 1'b1, 1};
    vecs[5]  = '{1'b1, 32'h0000_0000, 6'd31, 32'h0000_0000, 1'b1, 1};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFF, 6'd31, 32'hFFFF_FFFF, 1'b0, 1};
    vecs[7]  = '{1'b0, 32'h0001_0000, 6'd15, 32'h8000_0000, 1'b0, 17};
    vecs[8]  = '{1'b1, 32'h7FFF_FFFF, 6'd0,  32'h7FFF_FFFF, 1'b0, 2};
    vecs[9]  = '{1'b0, 32'h0000_00FF, 6'd24, 32'hFF00_0000, 1'b0, 26};
    vecs[10] = '{1'b1, 32'h0000_00FF, 6'd23, 32'h7F80_0000, 1'b0, 25};
    vecs[11] = '{1'b0, 32'h1234_5678, 6'd3,  32'h91A2_B3C0, 1'b0, 5};

    // Reset state
    #12;
    chk("reset_busy",   32'(busy),  32'd0);
    chk("reset_done",   32'(done),  32'd0);
    chk("reset_result", result,     32'd0);
    chk("reset_shamt",  32'(shamt), 32'd0);
    chk("reset_zero",   32'(zero),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      launch(vecs[i].mode, vecs[i].data);
      wait_done(lat, bok);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
      chk($sformatf("v%0d_result", i), result, vecs[i].result);
      chk($sformatf("v%0d_shamt", i), 32'(shamt), 32'(vecs[i].shamt));
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {30'd0, busy, done}, 32'd0);
      chk($sformatf("v%0d_hold", i), result, vecs[i].result);
      $display("vec %0d mode=%0d data=%h -> shamt=%0d result=%h zero=%0d lat=%0d",
               i, vecs[i].mode, vecs[i].data, shamt, result, zero, lat);
    end

    // Start while busy is ignored; the in-flight op completes untouched.
    launch(1'b0, 32'h0000_0001);
    repeat (5) @(negedge clk);
    start = 1'b1; mode = 1'b0; data_in = 32'h0000_00FF;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bok);
    chk("busy_start_latency", (lat < 0) ? 32'hFFFF_FFFF : 32'(lat + 6), 32'd33);
    chk("busy_start_shamt", 32'(shamt), 32'd31);
    chk("busy_start_result", result, 32'h8000_0000);
    $display("ignored start: first op shamt=%0d result=%h", shamt, result);
    launch(1'b0, 32'h0000_00FF);
    wait_done(lat, bok);
    chk("after_done_latency", 32'(lat), 32'd26);
    chk("after_done_shamt", 32'(shamt), 32'd24);
    $display("start after done: shamt=%0d result=%h", shamt, result);

    // Reset mid-operation aborts with no done pulse.
    launch(1'b0, 32'h0000_0001);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   32'(busy),  32'd0);
    chk("abort_done",   32'(done),  32'd0);
    chk("abort_result", result,     32'd0);
    chk("abort_shamt",  32'(shamt), 32'd0);
    chk("abort_zero",   32'(zero),  32'd0);
    begin
      bit saw_done = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      chk("abort_no_done", 32'(saw_done), 32'd0);
    end
    $display("reset abort: outputs cleared, no done pulse");
    launch(1'b0, 32'h0001_0000);
    wait_done(lat, bok);
    chk("post_reset_latency", 32'(lat), 32'd17);
    chk("post_reset_shamt", 32'(shamt), 32'd15);
    chk("post_reset_result", result, 32'h8000_0000);
    $display("post reset: shamt=%0d result=%h", shamt, result);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
